sprite_line_scheduler: RTL and testbench

- Per-scanline scheduler that shares the 16x16 sprite ROMs (platform and player) among up to NUM_OBJ on-screen objects.
- During horizontal blanking it scans the object table and loads the objects that intersect the next line into MAX_SLOTS line slots.
- During active video it drives the ROM coordinate inputs and select for the highest-priority object covering the current pixel.
- Sits between game logic (object writes) and the colour mapper (VGA DrawX/DrawY).

---
 rtl/sprite_pkg.sv | 45 ++++
 rtl/sprite_slot_match.sv | 27 ++
 rtl/sprite_line_scheduler.sv | 273 +++++++++++++++++++++++++++
 tb/tb_sprite_line_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite line scheduler.
//
// Contents:
//   SPR_W, SPR_H, V_TOTAL  sprite footprint and frame height
//   obj_t                  one object table entry
//   slot_t                 one per-line render slot
//   sched_state_t          scan FSM states
//   in_span()              column/row offset range test
//
// Optional feature: define SPRITE_SCHED_HFLIP_EN to add a per-entry and
// per-slot horizontal mirror bit.

package sprite_pkg;

    localparam int unsigned SPR_W   = 16;
    localparam int unsigned SPR_H   = 16;
    localparam int unsigned V_TOTAL = 525;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       kind;   // 0 = platform, 1 = player
        logic       valid;
`ifdef SPRITE_SCHED_HFLIP_EN
        logic       flip;
`endif
    } obj_t;

    typedef struct packed {
        logic [9:0] x;
        logic [3:0] dy;
        logic       kind;
`ifdef SPRITE_SCHED_HFLIP_EN
        logic       flip;
`endif
    } slot_t;

    typedef enum logic [1:0] {IDLE, SCAN, SWAP} sched_state_t;

    // True when a 10-bit unsigned offset lies inside a sprite of the given span.
    function automatic logic in_span(input logic [9:0] diff, input int unsigned span);
        return diff < 10'(span);
    endfunction

endpackage

// File: rtl/sprite_slot_match.sv
// Combinational hit test for one active line slot.
//
// Ports:
//   pos_i  current pixel column (DrawX)
//   org_i  slot left column
//   en_i   slot holds an object for this line
//   hit_o  pixel lies within the slot's 16 columns
//   off_o  column offset into the sprite (valid when hit_o)

module sprite_slot_match
    import sprite_pkg::*;
(
    input  logic [9:0] pos_i,
    input  logic [9:0] org_i,
    input  logic       en_i,
    output logic       hit_o,
    output logic [3:0] off_o
);

    logic [9:0] diff;

    // Modulo-1024 difference: columns left of the slot wrap to large values.
    assign diff  = pos_i - org_i;
    assign hit_o = en_i && in_span(diff, SPR_W);
    assign off_o = diff[3:0];

endmodule

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler. During hblank it scans the object table
// (one entry per cycle) and loads up to MAX_SLOTS objects touching the next
// line into shadow slots, then swaps them into the active slots. During
// active video it picks the lowest-numbered active slot covering DrawX and
// drives the sprite ROM coordinates, one cycle after DrawX.
//
// Ports:
//   Clk, Reset_n                clock, asynchronous active-low reset
//   obj_we/obj_idx/obj_*        object table write port
//   line_start                  hblank pulse; DrawY holds the finished line
//   DrawX, DrawY                current pixel
//   rom_x, rom_y, rom_sel, hit  registered ROM coordinates and select
//   overflow                    sticky: some line had too many candidates
//   busy                        scan or swap in progress
//
// Optional feature: SPRITE_SCHED_HFLIP_EN adds horizontal mirroring.

module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int unsigned NUM_OBJ   = 16,
    parameter int unsigned MAX_SLOTS = 4,
    parameter int unsigned V_TOTAL   = 525
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       obj_we,
    input  logic [$clog2(NUM_OBJ)-1:0] obj_idx,
    input  logic [9:0]                 obj_x,
    input  logic [9:0]                 obj_y,
    input  logic                       obj_type,
    input  logic                       obj_valid,
    input  logic                       obj_flip,
    input  logic                       line_start,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    output logic [9:0]                 rom_x,
    output logic [9:0]                 rom_y,
    output logic                       rom_sel,
    output logic                       hit,
    output logic                       overflow,
    output logic                       busy
);

    localparam int unsigned IW  = $clog2(NUM_OBJ);
    localparam int unsigned CW  = $clog2(NUM_OBJ + 1);
    localparam int unsigned SW  = (MAX_SLOTS > 1) ? $clog2(MAX_SLOTS) : 1;
    localparam int unsigned SCW = $clog2(MAX_SLOTS + 1);

    // ------------------------------------------------------------------
    // Object table
    // ------------------------------------------------------------------
    obj_t tbl_q [NUM_OBJ];
    obj_t wr_obj;

    always_comb begin
        wr_obj       = '0;
        wr_obj.x     = obj_x;
        wr_obj.y     = obj_y;
        wr_obj.kind  = obj_type;
        wr_obj.valid = obj_valid;
`ifdef SPRITE_SCHED_HFLIP_EN
        wr_obj.flip  = obj_flip;
`endif
    end

`ifndef SPRITE_SCHED_HFLIP_EN
    logic unused_flip;
    assign unused_flip = obj_flip;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_OBJ; i++) tbl_q[i] <= '0;
        end else if (obj_we) begin
            tbl_q[obj_idx] <= wr_obj;
        end
    end

    // ------------------------------------------------------------------
    // Scan FSM
    // ------------------------------------------------------------------
    sched_state_t state_q, state_d;

    logic [CW-1:0]  idx_q, idx_d;
    logic [9:0]     tgt_q, tgt_d;
    obj_t           ent_q, ent_d;       // entry fetched last cycle
    logic           ent_vld_q, ent_vld_d;
    slot_t          sh_slot_q [MAX_SLOTS];
    slot_t          sh_slot_d [MAX_SLOTS];
    slot_t          act_slot_q [MAX_SLOTS];
    slot_t          act_slot_d [MAX_SLOTS];
    logic [SCW-1:0] sh_cnt_q, sh_cnt_d;
    logic [SCW-1:0] act_cnt_q, act_cnt_d;
    logic           ovf_q, ovf_d;

    logic [9:0] scan_diff;
    logic       cand;
    slot_t      new_slot;

    // Rows above the object (tgt < y) are rejected rather than wrapped.
    assign scan_diff = tgt_q - ent_q.y;
    assign cand      = ent_vld_q && ent_q.valid && (tgt_q >= ent_q.y) &&
                       in_span(scan_diff, SPR_H);

    always_comb begin
        new_slot      = '0;
        new_slot.x    = ent_q.x;
        new_slot.dy   = scan_diff[3:0];
        new_slot.kind = ent_q.kind;
`ifdef SPRITE_SCHED_HFLIP_EN
        new_slot.flip = ent_q.flip;
`endif
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = SCAN;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                SCAN: if (idx_q == CW'(NUM_OBJ)) state_d = SWAP;
                SWAP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Scan datapath. The table read is pipelined one cycle: idx_q fetches an
    // entry, and the entry is classified the following cycle (ent_q), so the
    // scan spends NUM_OBJ+1 cycles in SCAN.
    always_comb begin
        idx_d      = idx_q;
        tgt_d      = tgt_q;
        ent_d      = tbl_q[idx_q[IW-1:0]];
        ent_vld_d  = 1'b0;
        sh_slot_d  = sh_slot_q;
        sh_cnt_d   = sh_cnt_q;
        act_slot_d = act_slot_q;
        act_cnt_d  = act_cnt_q;
        ovf_d      = ovf_q;

        if (line_start) begin
            // Starts a fresh scan, also aborting one in flight.
            tgt_d    = (DrawY == 10'(V_TOTAL - 1)) ? 10'd0 : DrawY + 10'd1;
            idx_d    = '0;
            sh_cnt_d = '0;
        end else begin
            unique case (state_q)
                SCAN: begin
                    ent_vld_d = (idx_q < CW'(NUM_OBJ));
                    idx_d     = idx_q + CW'(1);
                    if (cand) begin
                        if (sh_cnt_q < SCW'(MAX_SLOTS)) begin
                            sh_slot_d[SW'(sh_cnt_q)] = new_slot;
                            sh_cnt_d                 = sh_cnt_q + SCW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                SWAP: begin
                    act_slot_d = sh_slot_q;
                    act_cnt_d  = sh_cnt_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q     <= '0;
            tgt_q     <= '0;
            ent_q     <= '0;
            ent_vld_q <= 1'b0;
            sh_cnt_q  <= '0;
            act_cnt_q <= '0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < MAX_SLOTS; k++) begin
                sh_slot_q[k]  <= '0;
                act_slot_q[k] <= '0;
            end
        end else begin
            idx_q      <= idx_d;
            tgt_q      <= tgt_d;
            ent_q      <= ent_d;
            ent_vld_q  <= ent_vld_d;
            sh_cnt_q   <= sh_cnt_d;
            act_cnt_q  <= act_cnt_d;
            ovf_q      <= ovf_d;
            sh_slot_q  <= sh_slot_d;
            act_slot_q <= act_slot_d;
        end
    end

    assign overflow = ovf_q;

    // ------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------
    logic [MAX_SLOTS-1:0] slot_en;
    logic [MAX_SLOTS-1:0] slot_hit;
    logic [3:0]           slot_off [MAX_SLOTS];

    always_comb begin
        slot_en = '0;
        for (int k = 0; k < MAX_SLOTS; k++) slot_en[k] = (SCW'(k) < act_cnt_q);
    end

    for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_match
        sprite_slot_match u_match (
            .pos_i (DrawX),
            .org_i (act_slot_q[g].x),
            .en_i  (slot_en[g]),
            .hit_o (slot_hit[g]),
            .off_o (slot_off[g])
        );
    end

    logic       pix_hit;
    logic [9:0] pix_x, pix_y;
    logic       pix_sel;

    // Walk from the highest slot down so the lowest hitting slot wins.
    always_comb begin
        pix_hit = 1'b0;
        pix_x   = '0;
        pix_y   = '0;
        pix_sel = 1'b0;
        for (int k = MAX_SLOTS - 1; k >= 0; k--) begin
            if (slot_hit[k]) begin
                pix_hit = 1'b1;
                pix_y   = {6'd0, act_slot_q[k].dy};
                pix_sel = act_slot_q[k].kind;
`ifdef SPRITE_SCHED_HFLIP_EN
                pix_x   = act_slot_q[k].flip ? {6'd0, 4'hF - slot_off[k]}
                                             : {6'd0, slot_off[k]};
`else
                pix_x   = {6'd0, slot_off[k]};
`endif
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit     <= 1'b0;
            rom_x   <= '0;
            rom_y   <= '0;
            rom_sel <= 1'b0;
        end else begin
            hit     <= pix_hit;
            rom_x   <= pix_x;
            rom_y   <= pix_y;
            rom_sel <= pix_sel;
        end
    end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Self-checking bench for sprite_line_scheduler: a vector table of single-
// object lines, hand sequences for priority, overflow, scan abort and reset,
// and randomized lines checked against a list-based reference model.

module tb_sprite_line_scheduler;

    localparam int NOBJ  = 16;
    localparam int NSLOT = 4;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       obj_we;
    logic [3:0] obj_idx;
    logic [9:0] obj_x, obj_y;
    logic       obj_type, obj_valid, obj_flip;
    logic       line_start;
    logic [9:0] DrawX, DrawY;
    logic [9:0] rom_x, rom_y;
    logic       rom_sel, hit, overflow, busy;

    sprite_line_scheduler dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .obj_we     (obj_we),
        .obj_idx    (obj_idx),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_type   (obj_type),
        .obj_valid  (obj_valid),
        .obj_flip   (obj_flip),
        .line_start (line_start),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .rom_x      (rom_x),
        .rom_y      (rom_y),
        .rom_sel    (rom_sel),
        .hit        (hit),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int m_x [NOBJ], m_y [NOBJ], m_typ [NOBJ], m_val [NOBJ], m_flip [NOBJ];
    int a_n;
    int a_x [NSLOT], a_dy [NSLOT], a_typ [NSLOT], a_flip [NSLOT];
    int m_ovf;

    function automatic void model_reset();
        for (int i = 0; i < NOBJ; i++) m_val[i] = 0;
        a_n   = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_line(input int line);
        int tgt, n;
        tgt = (line == 524) ? 0 : line + 1;
        n   = 0;
        for (int i = 0; i < NOBJ; i++) begin
            if (m_val[i] != 0 && tgt >= m_y[i] && tgt - m_y[i] <= 15) begin
                if (n < NSLOT) begin
                    a_x[n] = m_x[i]; a_dy[n] = tgt - m_y[i];
                    a_typ[n] = m_typ[i]; a_flip[n] = m_flip[i];
                    n++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        a_n = n;
    endfunction

    function automatic void model_pix(input int px, output int eh, output int ex,
                                      output int ey, output int es);
        eh = 0; ex = 0; ey = 0; es = 0;
        for (int s = a_n - 1; s >= 0; s--) begin
            int d;
            d = (px - a_x[s] + 1024) % 1024;
            if (d <= 15) begin
                eh = 1; ey = a_dy[s]; es = a_typ[s];
`ifdef SPRITE_SCHED_HFLIP_EN
                ex = (a_flip[s] != 0) ? 15 - d : d;
`else
                ex = d;
`endif
            end
        end
    endfunction

    // ---------------- drivers ----------------
    task automatic write_obj(input int idx, input int x, input int y, input int typ,
                             input int val, input int flip);
        obj_we = 1'b1; obj_idx = 4'(idx); obj_x = 10'(x); obj_y = 10'(y);
        obj_type = typ[0]; obj_valid = val[0]; obj_flip = flip[0];
        tick();
        obj_we = 1'b0;
        m_x[idx] = x; m_y[idx] = y; m_typ[idx] = typ; m_val[idx] = val; m_flip[idx] = flip;
    endtask

    task automatic do_line(input int line, output int nbusy);
        DrawY = 10'(line); line_start = 1'b1;
        tick();
        line_start = 1'b0;
        nbusy = 0;
        while (busy && nbusy < 40) begin
            nbusy++;
            tick();
        end
        model_line(line);
    endtask

    task automatic probe_exp(input string tag, input int px, input int eh, input int ex,
                             input int ey, input int es);
        DrawX = 10'(px);
        tick();
        check({tag, ".hit"}, int'(hit), eh);
        check({tag, ".rom_x"}, int'(rom_x), ex);
        check({tag, ".rom_y"}, int'(rom_y), ey);
        check({tag, ".rom_sel"}, int'(rom_sel), es);
    endtask

    task automatic probe_model(input string tag, input int px);
        int eh, ex, ey, es;
        model_pix(px, eh, ex, ey, es);
        probe_exp(tag, px, eh, ex, ey, es);
    endtask

    typedef struct {
        string name;
        int x, y, typ, line, px;
        int e_hit, e_rx, e_ry, e_sel;
    } vec_t;

    initial begin
        vec_t vecs [7];
        int nb;
        int flip_rx;

        vecs[0] = '{"player_basic", 100,   50, 1,  55, 103, 1,  3,  6, 1};
        vecs[1] = '{"wrap_line",      0,    0, 0, 524,   0, 1,  0,  0, 0};
        vecs[2] = '{"y_wrap_miss",    0, 1020, 0,   3,   2, 0,  0,  0, 0};
        vecs[3] = '{"dy_15",        100,   50, 0,  64, 115, 1, 15, 15, 0};
        vecs[4] = '{"dy_16_miss",   100,   50, 0,  65, 103, 0,  0,  0, 0};
        vecs[5] = '{"dx_16_miss",   100,   50, 1,  55, 116, 0,  0,  0, 0};
        vecs[6] = '{"dx_left_miss", 100,   50, 1,  55,  99, 0,  0,  0, 0};

        Reset_n = 1'b0; obj_we = 1'b0; obj_idx = '0; obj_x = '0; obj_y = '0;
        obj_type = 1'b0; obj_valid = 1'b0; obj_flip = 1'b0; line_start = 1'b0;
        DrawX = '0; DrawY = '0;
        model_reset();
        repeat (2) tick();

        // Reset state
        check("rst.hit", int'(hit), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.overflow", int'(overflow), 0);
        check("rst.rom_x", int'(rom_x), 0);
        check("rst.rom_y", int'(rom_y), 0);
        check("rst.rom_sel", int'(rom_sel), 0);
        Reset_n = 1'b1;
        tick();

        // Vector table: one object at index 0
        for (int v = 0; v < 7; v++) begin
            write_obj(0, vecs[v].x, vecs[v].y, vecs[v].typ, 1, 0);
            do_line(vecs[v].line, nb);
            check({vecs[v].name, ".busy_len"}, nb, 18);
            probe_exp(vecs[v].name, vecs[v].px, vecs[v].e_hit, vecs[v].e_rx,
                      vecs[v].e_ry, vecs[v].e_sel);
        end

        // Priority: overlapping player (idx 0) and platform (idx 1)
        write_obj(0, 100, 50, 1, 1, 0);
        write_obj(1, 100, 50, 0, 1, 0);
        do_line(55, nb);
        probe_exp("prio_overlap", 105, 1, 5, 6, 1);
        probe_exp("prio_edge", 116, 0, 0, 0, 0);
        write_obj(1, 110, 50, 0, 1, 0);
        do_line(55, nb);
        probe_exp("prio_plat_only", 120, 1, 10, 6, 0);

        // Abort: restart at scan cycle 5, active slots hold until the swap
        write_obj(1, 0, 0, 0, 0, 0);
        write_obj(0, 300, 100, 1, 1, 0);
        do_line(105, nb);
        probe_exp("abort_pre", 303, 1, 3, 6, 1);
        DrawY = 10'd110; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (4) begin
            tick();
            check("abort_hold_first", int'(rom_y), 6);
        end
        DrawY = 10'd112; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        nb = 0;
        while (busy && nb < 40) begin
            check("abort_hold", int'(rom_y), 6);
            nb++;
            tick();
        end
        check("abort_busy_len", nb, 18);
        tick();
        check("abort_new_y", int'(rom_y), 13);
        model_line(112);

        // Overflow: five candidates, only slots for indices 0-3
        check("ovf_before", int'(overflow), 0);
        for (int i = 0; i < 5; i++) write_obj(i, i * 20, 200, 0, 1, 0);
        do_line(205, nb);
        check("ovf_set", int'(overflow), 1);
        probe_exp("ovf_idx3", 65, 1, 5, 6, 0);
        probe_exp("ovf_idx4_dropped", 85, 0, 0, 0, 0);
        do_line(10, nb);
        check("ovf_sticky", int'(overflow), 1);

        // Randomized lines against the reference model
        for (int it = 0; it < 40; it++) begin
            int line, tgt, nw;
            line = $urandom_range(0, 524);
            tgt  = (line == 524) ? 0 : line + 1;
            nw   = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                int y;
                if ($urandom_range(0, 3) == 0) y = $urandom_range(0, 1023);
                else y = (tgt - int'($urandom_range(0, 18)) + 1024) % 1024;
                write_obj($urandom_range(0, NOBJ - 1), $urandom_range(0, 620), y,
                          $urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? 1 : 0,
                          $urandom_range(0, 1));
            end
            do_line(line, nb);
            check("rnd.busy_len", nb, 18);
            check("rnd.overflow", int'(overflow), m_ovf);
            for (int p = 0; p < 6; p++) begin
                int px;
                if (a_n > 0 && p < 4)
                    px = (a_x[$urandom_range(0, a_n - 1)] + int'($urandom_range(0, 17))) % 1024;
                else
                    px = $urandom_range(0, 639);
                probe_model("rnd", px);
            end
        end

        // Horizontal flip (mirrored only when the feature is built in)
`ifdef SPRITE_SCHED_HFLIP_EN
        flip_rx = 12;
`else
        flip_rx = 3;
`endif
        write_obj(0, 100, 50, 1, 1, 1);
        do_line(55, nb);
        probe_exp("flip", 103, 1, flip_rx, 6, 1);

        // Reset in the middle of a scan
        check("pre_rst.overflow", int'(overflow), 1);
        DrawY = 10'd55; line_start = 1'b1;
        tick();
        line_start = 1'b0;
        tick();
        check("pre_rst.busy", int'(busy), 1);
        check("pre_rst.hit", int'(hit), 1);
        Reset_n = 1'b0;
        #1;
        check("mid_rst.busy", int'(busy), 0);
        check("mid_rst.hit", int'(hit), 0);
        check("mid_rst.overflow", int'(overflow), 0);
        check("mid_rst.rom_x", int'(rom_x), 0);
        #3;
        Reset_n = 1'b1;
        model_reset();
        tick();
        do_line(55, nb);
        probe_exp("post_rst_table_clear", 103, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
